tick_generator: RTL



---
 rtl/tick_generator.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tick_generator.sv
// Programmable down-counting tick source with continuous and one-shot modes.
// Optional prescaler on the decrement enable: define TICK_PRESCALE_EN.
module tick_generator #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned PRESCALE = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] period,
    output logic             tick,
    output logic             busy,
    output logic             expired,
    output logic [WIDTH-1:0] remaining
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             oneshot_q, oneshot_d;
    logic             tick_q, tick_d;
    logic             dec_en;

`ifdef TICK_PRESCALE_EN
    localparam int unsigned PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0] PSC_LAST = PSW'(PRESCALE - 1);

    logic [PSW-1:0] psc_q, psc_d;

    assign dec_en = (psc_q == PSC_LAST);

    always_comb begin
        psc_d = psc_q;
        if (stop || start || (state_q != S_RUN)) begin
            psc_d = '0;
        end else if (dec_en) begin
            psc_d = '0;
        end else begin
            psc_d = psc_q + PSW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign dec_en = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        period_d    = period_q;
        oneshot_d   = oneshot_q;
        tick_d      = 1'b0;

        if (stop) begin
            state_d     = S_IDLE;
            remaining_d = '0;
        end else if (start) begin
            state_d     = S_RUN;
            remaining_d = period;
            period_d    = period;
            oneshot_d   = oneshot;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (dec_en) begin
                        if (remaining_q != '0) begin
                            remaining_d = remaining_q - WIDTH'(1);
                        end else begin
                            // Expiry: pulse next cycle, then reload or park in EXPIRED.
                            tick_d = 1'b1;
                            if (oneshot_q) begin
                                state_d     = S_EXPIRED;
                                remaining_d = '0;
                            end else begin
                                remaining_d = period_q;
                            end
                        end
                    end
                end
                S_EXPIRED: begin
                    remaining_d = '0;
                end
                S_IDLE: begin
                    remaining_d = '0;
                end
                default: begin
                    state_d     = S_IDLE;
                    remaining_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            period_q    <= '0;
            oneshot_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            period_q    <= period_d;
            oneshot_q   <= oneshot_d;
            tick_q      <= tick_d;
        end
    end

    assign tick      = tick_q;
    assign busy      = (state_q == S_RUN);
    assign expired   = (state_q == S_EXPIRED);
    assign remaining = remaining_q;

endmodule
